// File: rtl/hyperbus_target_pkg.sv
// Shared HyperBus constants: one-hot FSM states, CA bit positions, register map, RWDS codes.
package hyperbus_target_pkg;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_CA    = 5'b00010,
        ST_LAT   = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_READ  = 5'b10000
    } state_e;

    localparam int CA_RW = 47;
    localparam int CA_AS = 46;
    localparam int CA_BT = 45;

    localparam logic [31:0] REG_ID0 = 32'h0000_0000;
    localparam logic [31:0] REG_ID1 = 32'h0000_0001;
    localparam logic [31:0] REG_CR0 = 32'h0000_0800;

    localparam logic [1:0] RWDS_VALID = 2'b10;

endpackage

// File: rtl/hyperbus_target_mem.sv
// Single-port DEPTH x 16 word array with per-byte write enables and a registered read.
module hyperbus_target_mem #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [1:0]               we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [15:0]              wdata,
    output logic [15:0]              rdata
);

    logic [15:0] mem [DEPTH];

    // A cycle with no byte enabled is a read; rdata holds otherwise.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we[1]) mem[addr][15:8] <= wdata[15:8];
            if (we[0]) mem[addr][7:0]  <= wdata[7:0];
            if (we == 2'b00) rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/hyperbus_target.sv
// HyperBus responder: decodes the 48-bit CA, counts initial latency and serves
// linear or wrapped bursts from a word array or a small register space.
module hyperbus_target
    import hyperbus_target_pkg::*;
#(
    parameter int          DEPTH      = 1024,
    parameter int          LATENCY    = 5,
    parameter int          FIXED_DBL  = 0,
    parameter int          WRAP_WORDS = 16,
    parameter logic [15:0] ID0        = 16'h0C81,
    parameter logic [15:0] ID1        = 16'h0001,
    parameter logic [15:0] CR0_RST    = 16'h8F1F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hbus_rstn_i,
    input  logic        hbus_csn_i,
    input  logic [15:0] hbus_dq_i,
    input  logic [1:0]  hbus_rwds_i,
    output logic [15:0] hbus_dq_o,
    output logic        hbus_dq_oe,
    output logic [1:0]  hbus_rwds_o,
    output logic        hbus_rwds_oe,
    output logic        busy,
    output logic [4:0]  state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(WRAP_WORDS);
    localparam logic [7:0] LAT_INIT = (FIXED_DBL != 0) ? 8'(2*LATENCY-1) : 8'(LATENCY-1);

    state_e      state, state_nx;
    logic [31:0] ca_hi;
    logic        ca_cnt;
    logic [7:0]  lat_cnt;
    logic [31:0] addr, addr_nx;
    logic        is_read, is_reg, is_lin, reg_done;
    logic        rd_valid;
    logic [15:0] dq_hold, cr0, reg_sel, reg_rdata, mem_rdata;
    logic        wr_fire, rd_fire, mem_en;
    logic [1:0]  mem_we;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (!hbus_csn_i) state_nx = ST_CA;
            ST_CA:    if (ca_cnt) state_nx = (!ca_hi[CA_RW-16] && ca_hi[CA_AS-16]) ? ST_WRITE : ST_LAT;
            ST_LAT:   if (lat_cnt == 8'd0) state_nx = is_read ? ST_READ : ST_WRITE;
            ST_WRITE: state_nx = ST_WRITE;
            ST_READ:  state_nx = ST_READ;
            default:  state_nx = ST_IDLE;
        endcase
        if (hbus_csn_i) state_nx = ST_IDLE;
    end

    assign wr_fire = (state == ST_WRITE) && !hbus_csn_i;
    assign rd_fire = (state == ST_READ) && !hbus_csn_i;
    assign mem_en  = (wr_fire || rd_fire) && !is_reg;
    assign mem_we  = (wr_fire && !is_reg) ? ~hbus_rwds_i : 2'b00;

    always_comb begin
        addr_nx = addr;
        if (is_lin) addr_nx[AW-1:0] = AW'(addr[AW-1:0] + 1'b1);
        else        addr_nx[WW-1:0] = WW'(addr[WW-1:0] + 1'b1);
    end

    always_comb begin
        reg_sel = 16'h0000;
        case (addr)
            REG_ID0: reg_sel = ID0;
            REG_ID1: reg_sel = ID1;
            REG_CR0: reg_sel = cr0;
            default: reg_sel = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ca_cnt   <= 1'b0;
            lat_cnt  <= 8'd0;
            rd_valid <= 1'b0;
            reg_done <= 1'b0;
            dq_hold  <= 16'h0000;
            cr0      <= CR0_RST;
        end else if (!hbus_rstn_i) begin
            state    <= ST_IDLE;
            ca_cnt   <= 1'b0;
            lat_cnt  <= 8'd0;
            rd_valid <= 1'b0;
            reg_done <= 1'b0;
            dq_hold  <= 16'h0000;
            cr0      <= CR0_RST;
        end else begin
            state    <= state_nx;
            rd_valid <= rd_fire;
            dq_hold  <= hbus_dq_o;
            if (state == ST_IDLE) ca_cnt <= 1'b0;
            if (state == ST_CA) begin
                ca_cnt <= 1'b1;
                if (ca_cnt) begin
                    lat_cnt  <= LAT_INIT;
                    reg_done <= 1'b0;
                end
            end
            if (state == ST_LAT && lat_cnt != 8'd0) lat_cnt <= lat_cnt - 8'd1;
            // Register writes take only the first data word of the burst.
            if (wr_fire && is_reg) begin
                reg_done <= 1'b1;
                if (!reg_done && addr == REG_CR0) cr0 <= hbus_dq_i;
            end
        end
    end

    // Datapath registers are only meaningful once their qualifying state is reached.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && !hbus_csn_i) ca_hi[31:16] <= hbus_dq_i;
        if (state == ST_CA && !ca_cnt) ca_hi[15:0] <= hbus_dq_i;
        if (state == ST_CA && ca_cnt) begin
            is_read <= ca_hi[CA_RW-16];
            is_reg  <= ca_hi[CA_AS-16];
            is_lin  <= ca_hi[CA_BT-16];
            addr    <= {ca_hi[28:0], hbus_dq_i[2:0]};
        end
        if (wr_fire || rd_fire) addr <= addr_nx;
        if (rd_fire) reg_rdata <= reg_sel;
    end

    hyperbus_target_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (addr[AW-1:0]),
        .wdata (hbus_dq_i),
        .rdata (mem_rdata)
    );

    // A read word is valid in the cycle rwds_o == RWDS_VALID; there is no
    // back-pressure, the leader must take it in that cycle.
    assign hbus_dq_o    = rd_valid ? (is_reg ? reg_rdata : mem_rdata) : dq_hold;
    assign hbus_dq_oe   = (state == ST_READ);
    assign hbus_rwds_oe = (state == ST_CA) || (state == ST_READ) || (state == ST_LAT && is_read);
    assign hbus_rwds_o  = (state == ST_CA) ? ((FIXED_DBL != 0) ? 2'b11 : 2'b00) :
                          ((state == ST_READ) && rd_valid) ? RWDS_VALID : 2'b00;
    assign busy         = (state != ST_IDLE);
    assign state_dbg    = state;

endmodule

// File: tb/tb_hyperbus_target.sv
// Bench for hyperbus_target: scripted leader transactions, read words checked through an expected queue.
module tb_hyperbus_target;
    import hyperbus_target_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LAT   = 5;

    logic clk = 1'b0, rst = 1'b1, rstn = 1'b1, csn = 1'b1, sel = 1'b0;
    logic [15:0] dq = 16'h0;
    logic [1:0]  rwds = 2'b00;
    logic csn_a, csn_b;

    logic [15:0] a_dq_o, b_dq_o, o_dq_o;
    logic [1:0]  a_rwds_o, b_rwds_o, o_rwds_o;
    logic        a_dq_oe, b_dq_oe, o_dq_oe, a_rwds_oe, b_rwds_oe, o_rwds_oe;
    logic        a_busy, b_busy, o_busy;
    logic [4:0]  a_st, b_st, o_st;

    logic        ob_busy, ob_dq_oe, ob_rwds_oe;
    logic [1:0]  ob_rwds_o;
    logic [4:0]  ob_st;

    logic [15:0] exp_q[$];
    logic [15:0] mdl [2][DEPTH];
    logic [15:0] cr0_m [2];
    logic [15:0] wd [8];
    logic [1:0]  wm [8];
    logic [15:0] mon_exp;
    int checks = 0, errors = 0;

    assign csn_a = csn | sel;
    assign csn_b = csn | ~sel;
    assign o_dq_o    = sel ? b_dq_o : a_dq_o;
    assign o_rwds_o  = sel ? b_rwds_o : a_rwds_o;
    assign o_dq_oe   = sel ? b_dq_oe : a_dq_oe;
    assign o_rwds_oe = sel ? b_rwds_oe : a_rwds_oe;
    assign o_busy    = sel ? b_busy : a_busy;
    assign o_st      = sel ? b_st : a_st;

    hyperbus_target #(.DEPTH(DEPTH), .LATENCY(LAT), .FIXED_DBL(0)) dut (
        .clk(clk), .rst(rst), .hbus_rstn_i(rstn), .hbus_csn_i(csn_a), .hbus_dq_i(dq),
        .hbus_rwds_i(rwds), .hbus_dq_o(a_dq_o), .hbus_dq_oe(a_dq_oe), .hbus_rwds_o(a_rwds_o),
        .hbus_rwds_oe(a_rwds_oe), .busy(a_busy), .state_dbg(a_st));

    hyperbus_target #(.DEPTH(DEPTH), .LATENCY(LAT), .FIXED_DBL(1)) dut_dbl (
        .clk(clk), .rst(rst), .hbus_rstn_i(rstn), .hbus_csn_i(csn_b), .hbus_dq_i(dq),
        .hbus_rwds_i(rwds), .hbus_dq_o(b_dq_o), .hbus_dq_oe(b_dq_oe), .hbus_rwds_o(b_rwds_o),
        .hbus_rwds_oe(b_rwds_oe), .busy(b_busy), .state_dbg(b_st));

    // Clock and reset
    always #5 clk = ~clk;

    // Scoreboard: every valid read word pops one expected value.
    always @(negedge clk) begin
        if (o_dq_oe && o_rwds_oe && o_rwds_o == 2'b10) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %h with no word expected", o_dq_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (o_dq_o !== mon_exp) begin
                    errors++;
                    $display("FAIL rd_data: got %h want %h", o_dq_o, mon_exp);
                end
            end
        end
    end

    function automatic logic [15:0] reg_model(input logic [31:0] a);
        if (a == 32'h0)   return 16'h0C81;
        if (a == 32'h1)   return 16'h0001;
        if (a == 32'h800) return cr0_m[int'(sel)];
        return 16'h0000;
    endfunction

    function automatic logic [31:0] nxt(input logic [31:0] p, input logic lin);
        logic [31:0] r;
        r = p;
        if (lin) r[9:0] = p[9:0] + 10'd1;
        else     r[3:0] = p[3:0] + 4'd1;
        return r;
    endfunction

    // Driver: observe the current cycle's outputs, then drive the word for the next edge.
    task automatic cyc(input logic c, input logic [15:0] d, input logic [1:0] m);
        @(negedge clk);
        ob_busy = o_busy; ob_dq_oe = o_dq_oe; ob_rwds_oe = o_rwds_oe;
        ob_rwds_o = o_rwds_o; ob_st = o_st;
        csn = c; dq = d; rwds = m;
    endtask

    task automatic xfer(input logic rd, input logic rs, input logic lin,
                        input logic [31:0] a, input int n);
        logic [47:0] ca;
        logic [31:0] p;
        logic [15:0] w;
        logic [1:0]  ca_code;
        int lat;
        ca = {rd, rs, lin, a[31:3], 13'd0, a[2:0]};
        lat = sel ? 2*LAT : LAT;
        ca_code = sel ? 2'b11 : 2'b00;
        cyc(1'b0, ca[47:32], 2'b00);
        checks++;
        if (ob_busy !== 1'b0 || ob_dq_oe !== 1'b0 || ob_rwds_oe !== 1'b0) begin
            errors++;
            $display("FAIL start_idle: busy/dq_oe/rwds_oe got %b%b%b want 000", ob_busy, ob_dq_oe, ob_rwds_oe);
        end
        cyc(1'b0, ca[31:16], 2'b00);
        checks++;
        if (ob_st !== ST_CA || ob_rwds_oe !== 1'b1 || ob_rwds_o !== ca_code) begin
            errors++;
            $display("FAIL ca1_rwds: state %b oe %b rwds %b want %b 1 %b", ob_st, ob_rwds_oe, ob_rwds_o, ST_CA, ca_code);
        end
        cyc(1'b0, ca[15:0], 2'b00);
        checks++;
        if (ob_busy !== 1'b1 || ob_rwds_oe !== 1'b1 || ob_rwds_o !== ca_code) begin
            errors++;
            $display("FAIL ca2_rwds: busy %b oe %b rwds %b want 1 1 %b", ob_busy, ob_rwds_oe, ob_rwds_o, ca_code);
        end
        p = a;
        if (rd || !rs) begin
            for (int i = 0; i < lat; i++) begin
                cyc(1'b0, 16'($urandom), 2'($urandom));
                if (i == 0) begin
                    checks++;
                    if (ob_st !== ST_LAT || ob_rwds_oe !== rd) begin
                        errors++;
                        $display("FAIL lat_entry: state %b rwds_oe %b want %b %b", ob_st, ob_rwds_oe, ST_LAT, rd);
                    end
                end
            end
        end
        if (rd) begin
            for (int i = 0; i < n; i++) begin
                cyc(1'b0, 16'($urandom), 2'b00);
                if (i == 0) begin
                    checks++;
                    if (ob_dq_oe !== 1'b1 || ob_rwds_oe !== 1'b1 || ob_rwds_o !== 2'b00) begin
                        errors++;
                        $display("FAIL rd_cycle1: dq_oe %b rwds_oe %b rwds %b want 1 1 00", ob_dq_oe, ob_rwds_oe, ob_rwds_o);
                    end
                end
                if (i == 1) begin
                    checks++;
                    if (ob_rwds_o !== 2'b10) begin
                        errors++;
                        $display("FAIL rd_cycle2: rwds %b want 10", ob_rwds_o);
                    end
                end
                exp_q.push_back(rs ? reg_model(p) : mdl[int'(sel)][p[9:0]]);
                p = nxt(p, lin);
            end
            cyc(1'b1, 16'($urandom), 2'b00);
        end else begin
            for (int i = 0; i < n; i++) begin
                cyc(1'b0, wd[i], wm[i]);
                if (rs) begin
                    if (i == 0 && p == 32'h800) cr0_m[int'(sel)] = wd[i];
                end else begin
                    w = mdl[int'(sel)][p[9:0]];
                    if (!wm[i][1]) w[15:8] = wd[i][15:8];
                    if (!wm[i][0]) w[7:0]  = wd[i][7:0];
                    mdl[int'(sel)][p[9:0]] = w;
                end
                p = nxt(p, lin);
            end
            cyc(1'b1, 16'hFFFF, 2'b00);
        end
        cyc(1'b1, 16'h0000, 2'b00);
        checks++;
        if (ob_busy !== 1'b0 || ob_dq_oe !== 1'b0 || ob_rwds_oe !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL end_idle: busy %b dq_oe %b rwds_oe %b pending %0d want 0 0 0 0",
                     ob_busy, ob_dq_oe, ob_rwds_oe, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; csn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_dq_oe !== 1'b0 || o_rwds_oe !== 1'b0 || o_rwds_o !== 2'b00 ||
            o_dq_o !== 16'h0000 || o_st !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_outputs: busy %b dq_oe %b rwds_oe %b rwds %b dq %h st %b want all 0 st %b",
                     o_busy, o_dq_oe, o_rwds_oe, o_rwds_o, o_dq_o, o_st, ST_IDLE);
        end
        rst = 1'b0;
        cr0_m[0] = 16'h8F1F; cr0_m[1] = 16'h8F1F;
        @(negedge clk);
    endtask

    task automatic test_linear();
        wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h4444;
        for (int i = 0; i < 4; i++) wm[i] = 2'b00;
        xfer(1'b0, 1'b0, 1'b1, 32'h10, 4);
        xfer(1'b1, 1'b0, 1'b1, 32'h10, 4);
    endtask

    task automatic test_masked_write();
        wd[0] = 16'hABCD; wm[0] = 2'b10;
        xfer(1'b0, 1'b0, 1'b1, 32'h10, 1);
        checks++;
        if (mdl[0][16] !== 16'h11CD) begin
            errors++;
            $display("FAIL mask_model: got %h want 11cd", mdl[0][16]);
        end
        xfer(1'b1, 1'b0, 1'b1, 32'h10, 1);
    endtask

    task automatic test_wrap();
        wd[0] = 16'h5E5E; wd[1] = 16'h5F5F; wm[0] = 2'b00; wm[1] = 2'b00;
        xfer(1'b0, 1'b0, 1'b1, 32'h1E, 2);
        xfer(1'b1, 1'b0, 1'b0, 32'h1E, 4);
        wd[0] = 16'hA0A0; wd[1] = 16'hB0B0;
        xfer(1'b0, 1'b0, 1'b1, 32'h3FF, 2);
        xfer(1'b1, 1'b0, 1'b1, 32'h3FF, 2);
    endtask

    task automatic test_registers();
        xfer(1'b1, 1'b1, 1'b1, 32'h0, 2);
        wd[0] = 16'h8F17; wm[0] = 2'b11;
        xfer(1'b0, 1'b1, 1'b1, 32'h800, 1);
        xfer(1'b1, 1'b1, 1'b1, 32'h800, 1);
        xfer(1'b1, 1'b1, 1'b1, 32'h5, 1);
        wd[0] = 16'hA5A5; wd[1] = 16'h5A5A; wm[0] = 2'b00; wm[1] = 2'b00;
        xfer(1'b0, 1'b1, 1'b1, 32'h800, 2);
        xfer(1'b1, 1'b1, 1'b1, 32'h800, 1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        cr0_m[0] = 16'h8F1F; cr0_m[1] = 16'h8F1F;
        xfer(1'b1, 1'b1, 1'b1, 32'h800, 1);
        wd[0] = 16'h1234;
        xfer(1'b0, 1'b1, 1'b1, 32'h800, 1);
        @(negedge clk) rstn = 1'b0;
        @(negedge clk) rstn = 1'b1;
        cr0_m[0] = 16'h8F1F; cr0_m[1] = 16'h8F1F;
        xfer(1'b1, 1'b1, 1'b1, 32'h800, 1);
    endtask

    task automatic test_abort();
        cyc(1'b0, 16'h2000, 2'b00);
        cyc(1'b1, 16'h0000, 2'b00);
        xfer(1'b1, 1'b0, 1'b1, 32'h11, 2);
    endtask

    task automatic test_fixed_dbl();
        sel = 1'b1;
        wd[0] = 16'hC0DE; wd[1] = 16'hBEEF; wm[0] = 2'b00; wm[1] = 2'b00;
        xfer(1'b0, 1'b0, 1'b1, 32'h40, 2);
        xfer(1'b1, 1'b0, 1'b1, 32'h40, 2);
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_linear();
        test_masked_write();
        test_wrap();
        test_registers();
        test_abort();
        test_fixed_dbl();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
